// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte-stream writer for the 32x32 text buffer
// Optional scrolling with per-row clear is enabled by defining TEXT_CONSOLE_SCROLL_EN.
module text_console_writer #(
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       i_pix_clk,
    input  logic       i_reset_n,
    input  logic       i_char_valid,
    input  logic [7:0] i_char,
    output logic       o_char_ready,
    output logic       o_wr_en,
    output logic [9:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [4:0] o_cursor_col,
    output logic [4:0] o_cursor_row,
    output logic [4:0] o_scroll_row,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR
`ifdef TEXT_CONSOLE_SCROLL_EN
        , ROW_CLEAR
`endif
    } state_t;

    state_t     state, state_n;
    logic [4:0] col, col_n;
    logic [4:0] row, row_n;
    logic [9:0] cnt, cnt_n;
    logic       wr_en_n;
    logic [9:0] wr_addr_n;
    logic [7:0] wr_data_n;
    logic       advance;
`ifdef TEXT_CONSOLE_SCROLL_EN
    logic       full, full_n;
`endif

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            col       <= 5'd0;
            row       <= 5'd0;
            cnt       <= 10'd0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= 10'd0;
            o_wr_data <= 8'd0;
`ifdef TEXT_CONSOLE_SCROLL_EN
            full      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            cnt       <= cnt_n;
            o_wr_en   <= wr_en_n;
            o_wr_addr <= wr_addr_n;
            o_wr_data <= wr_data_n;
`ifdef TEXT_CONSOLE_SCROLL_EN
            full      <= full_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        cnt_n     = cnt;
        wr_en_n   = 1'b0;
        wr_addr_n = o_wr_addr;
        wr_data_n = o_wr_data;
        advance   = 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
        full_n    = full;
`endif
        case (state)
            IDLE: begin
                if (i_char_valid) begin
                    if (i_char >= 8'h20 && i_char <= 8'h7E) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = {row, col};
                        wr_data_n = i_char;
                        col_n     = col + 5'd1;
                        advance   = (col == 5'd31);
                    end else begin
                        case (i_char)
                            8'h0D: col_n = 5'd0;
                            8'h0A: advance = 1'b1;
                            8'h08: begin
                                if (col != 5'd0) begin
                                    col_n     = col - 5'd1;
                                    wr_en_n   = 1'b1;
                                    wr_addr_n = {row, col - 5'd1};
                                    wr_data_n = FILL_CHAR;
                                end
                            end
                            8'h0C: begin
                                state_n = CLEAR;
                                cnt_n   = 10'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cnt;
                wr_data_n = FILL_CHAR;
                cnt_n     = cnt + 10'd1;
                if (cnt == 10'd1023) begin
                    state_n = IDLE;
                    col_n   = 5'd0;
                    row_n   = 5'd0;
`ifdef TEXT_CONSOLE_SCROLL_EN
                    full_n  = 1'b0;
`endif
                end
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            ROW_CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {row, cnt[4:0]};
                wr_data_n = FILL_CHAR;
                cnt_n     = cnt + 10'd1;
                if (cnt[4:0] == 5'd31) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase

        // Row advance wraps 31->0; with scrolling the new row is wiped first.
        if (advance) begin
            row_n = row + 5'd1;
`ifdef TEXT_CONSOLE_SCROLL_EN
            if (row == 5'd31) full_n = 1'b1;
            state_n = ROW_CLEAR;
            cnt_n   = 10'd0;
`endif
        end
    end

    assign o_char_ready = (state == IDLE);
    assign o_busy       = (state != IDLE);
    assign o_cursor_col = col;
    assign o_cursor_row = row;
`ifdef TEXT_CONSOLE_SCROLL_EN
    assign o_scroll_row = full ? row + 5'd1 : 5'd0;
`else
    assign o_scroll_row = 5'd0;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - randomized self-checking bench for text_console_writer
module tb_text_console_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] ch = 8'h00;
    logic       ready, wr_en, busy;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] ccol, crow, scroll;

    text_console_writer #(.FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .i_pix_clk(clk), .i_reset_n(rst_n), .i_char_valid(valid), .i_char(ch),
        .o_char_ready(ready), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_cursor_col(ccol), .o_cursor_row(crow), .o_scroll_row(scroll), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: expected write sequence plus cursor/scroll state.
    logic [17:0] exp_q[$];
    int          mrow = 0, mcol = 0;
    bit          mfull = 1'b0;
    logic [9:0]  last_addr = '0;
    logic [7:0]  last_data = '0;
    int          nwrites = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int exp_scroll();
`ifdef TEXT_CONSOLE_SCROLL_EN
        return mfull ? (mrow + 1) % 32 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic m_clear_all();
        for (int a = 0; a < 1024; a++) exp_q.push_back({a[9:0], 8'h20});
        mrow = 0; mcol = 0; mfull = 1'b0;
    endtask

    task automatic m_advance();
        mrow = (mrow + 1) % 32;
`ifdef TEXT_CONSOLE_SCROLL_EN
        if (mrow == 0) mfull = 1'b1;
        for (int c = 0; c < 32; c++) exp_q.push_back({10'(mrow * 32 + c), 8'h20});
`endif
    endtask

    task automatic m_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({10'(mrow * 32 + mcol), b});
            mcol++;
            if (mcol == 32) begin
                mcol = 0;
                m_advance();
            end
        end else if (b == 8'h0D) mcol = 0;
        else if (b == 8'h0A) m_advance();
        else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                exp_q.push_back({10'(mrow * 32 + mcol), 8'h20});
            end
        end else if (b == 8'h0C) m_clear_all();
    endtask

    // Compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            chk("wr_en_in_reset", wr_en, 0);
        end else begin
            chk("busy_vs_ready", busy, !ready);
            if (wr_en) begin
                last_addr = wr_addr;
                last_data = wr_data;
                nwrites++;
                if (exp_q.size() == 0) chk("unexpected_write", wr_addr, -1);
                else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e[17:8]);
                    chk("wr_data", wr_data, e[7:0]);
                end
            end else if (ready && exp_q.size() == 0) begin
                chk("cursor_col", ccol, mcol);
                chk("cursor_row", crow, mrow);
                chk("scroll_row", scroll, exp_scroll());
            end
        end
    end

    task automatic send(input logic [7:0] b, output int waited);
        waited = 0;
        @(negedge clk);
        valid = 1'b1;
        ch = b;
        while (!ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) chk("send_ready_timeout", waited, -1);
        else m_apply(b);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        int w;
        send(b, w);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_q.size() != 0 || !ready) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", (w < 3000), 1);
    endtask

    initial begin
        int w;
        logic [7:0] b;
        // 1: reset with clear-on-reset
        repeat (3) @(negedge clk);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_col", ccol, 0);
        chk("reset_row", crow, 0);
        chk("reset_scroll", scroll, 0);
        chk("reset_ready", ready, 0);
        m_clear_all();
        rst_n = 1'b1;
        nwrites = 0;
        wait_idle();
        chk("initial_clear_writes", nwrites, 1024);
        chk("initial_cursor_col", ccol, 0);

        // 2: "AB" at (0,0)
        put(8'h41); put(8'h42);
        wait_idle();
        chk("ab_last_addr", last_addr, 1);
        chk("ab_last_data", last_data, 8'h42);
        chk("ab_col", ccol, 2);

        // 3: move to (31,3), write 'Z', then CR and BS at col 0
        put(8'h0D);
        repeat (3) put(8'h0A);
        repeat (31) put(8'h2E);
        put(8'h5A);
        wait_idle();
        chk("wrap_addr", last_addr, 10'h07F);
        chk("wrap_data", last_data, 8'h5A);
        chk("wrap_col", ccol, 0);
        chk("wrap_row", crow, 4);
        w = nwrites;
        put(8'h0D); put(8'h08);
        wait_idle();
        chk("cr_bs_no_write", nwrites, w);

        // 4: (5,31) LF wraps row to 0
        repeat (27) put(8'h0A);
        repeat (5) put(8'h2D);
        chk("pre_lf_row", crow, 31);
        w = nwrites;
        put(8'h0A);
        wait_idle();
        chk("lf_wrap_row", crow, 0);
        chk("lf_wrap_col", ccol, 5);
`ifdef TEXT_CONSOLE_SCROLL_EN
        chk("lf_wrap_writes", nwrites - w, 32);
        chk("lf_wrap_scroll", scroll, 1);
`else
        chk("lf_wrap_writes", nwrites - w, 0);
        chk("lf_wrap_scroll", scroll, 0);
`endif

        // 5: (4,2) backspace, then FF
        put(8'h0D); put(8'h0A); put(8'h0A);
        repeat (4) put(8'h61);
        put(8'h08);
        wait_idle();
        chk("bs_addr", last_addr, 10'h043);
        chk("bs_data", last_data, 8'h20);
        chk("bs_col", ccol, 3);
        put(8'h51);
        put(8'h0C);
        wait_idle();
        chk("ff_col", ccol, 0);
        chk("ff_row", crow, 0);

        // 6: byte held during clear, then reset mid-clear
        put(8'h0C);
        send(8'h41, w);
        chk("held_during_clear", (w >= 1000), 1);
        put(8'h0C);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midclr_wr_en", wr_en, 0);
        chk("midclr_col", ccol, 0);
        chk("midclr_row", crow, 0);
        chk("midclr_scroll", scroll, 0);
        m_clear_all();
        repeat (2) @(negedge clk);
        nwrites = 0;
        rst_n = 1'b1;
        wait_idle();
        chk("restart_clear_writes", nwrites, 1024);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 140) b = 8'($urandom_range(32, 126));
            else if (r < 155) b = 8'h0D;
            else if (r < 172) b = 8'h0A;
            else if (r < 188) b = 8'h08;
            else if (r < 198) b = 8'($urandom_range(127, 255));
            else b = 8'h0C;
            put(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
